af_sweep_ctrl: RTL and testbench

//  Autofocus sequencer for the VCM lens driver. Runs a coarse step sweep, then a

---
 rtl/af_sweep_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_af_sweep_ctrl.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/af_sweep_ctrl.sv
// Autofocus sweep sequencer: coarse sweep, then a fine sweep around the coarse
// peak, then park the lens at the best fine position.
// Optional feature macro: AF_TIMEOUT_EN. When it is defined, a measurement that
// sees TIMEOUT_FRAMES frames without a focus value counts as FV=0 and sets the
// sticky af_err flag. When it is undefined, af_err is tied low.
module af_sweep_ctrl #(
  parameter int unsigned STEP_W         = 11,
  parameter int unsigned FV_W           = 24,
  parameter int unsigned COARSE_INC     = 64,
  parameter int unsigned COARSE_MAX     = 'h3F0,
  parameter int unsigned FINE_INC       = 1,
  parameter int unsigned FINE_SPAN      = 16,
  parameter int unsigned SETTLE_FRAMES  = 2,
  parameter int unsigned TIMEOUT_FRAMES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              frame_end,
  input  logic [FV_W-1:0]   fv,
  input  logic              fv_valid,
  output logic [STEP_W-1:0] step,
  output logic              busy,
  output logic              af_done,
  output logic [STEP_W-1:0] peak_step,
  output logic [FV_W-1:0]   peak_fv,
  output logic              af_err
);

  // Step arithmetic is done one bit wider so sums can be range-checked without wrap.
  localparam int unsigned SW1 = STEP_W + 1;
  localparam int unsigned CntW = $clog2(SETTLE_FRAMES + 1);

  localparam logic [SW1-1:0]    CoarseInc  = SW1'(COARSE_INC);
  localparam logic [SW1-1:0]    CoarseMax  = SW1'(COARSE_MAX);
  localparam logic [SW1-1:0]    FineInc    = SW1'(FINE_INC);
  localparam logic [SW1-1:0]    FineSpan   = SW1'(FINE_SPAN);
  localparam logic [SW1-1:0]    StepMax    = {1'b0, {STEP_W{1'b1}}};
  localparam logic [CntW-1:0]   SettleLoad = CntW'(SETTLE_FRAMES);

  // Reject configurations that would deadlock the settle or timeout counters.
  if (SETTLE_FRAMES == 0 || TIMEOUT_FRAMES == 0) begin : g_cfg_check
    $error("af_sweep_ctrl: SETTLE_FRAMES and TIMEOUT_FRAMES must be >= 1");
  end

  typedef enum logic [2:0] {
    StIdle,
    StCSettle,
    StCMeas,
    StFSettle,
    StFMeas,
    StDone
  } state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [STEP_W-1:0]   fine_end_q;

  logic                in_meas;
  logic                timeout_hit;
  logic                meas_event;
  logic                upd;
  logic [STEP_W-1:0]   new_peak_step;
  logic [SW1-1:0]      step_ext;
  logic [SW1-1:0]      np_ext;
  logic [SW1-1:0]      coarse_nxt;
  logic [SW1-1:0]      fine_nxt;
  logic [SW1-1:0]      fine_hi_raw;
  logic [STEP_W-1:0]   fine_lo;
  logic [STEP_W-1:0]   fine_hi;

`ifdef AF_TIMEOUT_EN
  localparam int unsigned TcntW = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [TcntW-1:0] TcntLast = TcntW'(TIMEOUT_FRAMES - 1);

  logic [TcntW-1:0] tcnt_q;

  // A real focus value on the same cycle as the final frame wins over the timeout.
  assign timeout_hit = in_meas && frame_end && !fv_valid && (tcnt_q == TcntLast);

  // Frame counter while measuring, plus the sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt_q <= '0;
      af_err <= 1'b0;
    end else begin
      if (!in_meas || meas_event) begin
        tcnt_q <= '0;
      end else if (frame_end && !(abort)) begin
        tcnt_q <= tcnt_q + TcntW'(1);
      end
      if (state_q == StIdle && start) begin
        af_err <= 1'b0;
      end else if (timeout_hit && !abort) begin
        af_err <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign af_err      = 1'b0;
`endif

  // Peak update and next-position arithmetic for the measurement states.
  always_comb begin
    in_meas       = (state_q == StCMeas) || (state_q == StFMeas);
    meas_event    = in_meas && (fv_valid || timeout_hit);
    upd           = in_meas && fv_valid && (fv > peak_fv);
    new_peak_step = upd ? step : peak_step;
    step_ext      = {1'b0, step};
    np_ext        = {1'b0, new_peak_step};
    coarse_nxt    = step_ext + CoarseInc;
    fine_nxt      = step_ext + FineInc;
    fine_lo       = (np_ext < FineSpan) ? '0 : (new_peak_step - STEP_W'(FINE_SPAN));
    fine_hi_raw   = np_ext + FineSpan;
    fine_hi       = (fine_hi_raw > StepMax) ? {STEP_W{1'b1}} : fine_hi_raw[STEP_W-1:0];
  end

  // Sequencer FSM with registered outputs; abort has priority over frame events.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      fine_end_q <= '0;
      step       <= '0;
      busy       <= 1'b0;
      af_done    <= 1'b0;
      peak_step  <= '0;
      peak_fv    <= '0;
    end else begin
      af_done <= 1'b0;
      if (abort && state_q != StIdle) begin
        state_q <= StIdle;
        busy    <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              step      <= '0;
              peak_fv   <= '0;
              peak_step <= '0;
              cnt_q     <= SettleLoad;
              busy      <= 1'b1;
              state_q   <= StCSettle;
            end
          end
          StCSettle, StFSettle: begin
            if (frame_end) begin
              if (cnt_q == CntW'(1)) begin
                state_q <= (state_q == StCSettle) ? StCMeas : StFMeas;
              end else begin
                cnt_q <= cnt_q - CntW'(1);
              end
            end
          end
          StCMeas: begin
            if (meas_event) begin
              if (upd) begin
                peak_fv   <= fv;
                peak_step <= step;
              end
              cnt_q <= SettleLoad;
              if (coarse_nxt > CoarseMax) begin
                // Fine window is re-measured from scratch around the coarse peak.
                step       <= fine_lo;
                fine_end_q <= fine_hi;
                peak_fv    <= '0;
                state_q    <= StFSettle;
              end else begin
                step    <= coarse_nxt[STEP_W-1:0];
                state_q <= StCSettle;
              end
            end
          end
          StFMeas: begin
            if (meas_event) begin
              if (upd) begin
                peak_fv   <= fv;
                peak_step <= step;
              end
              if (fine_nxt > {1'b0, fine_end_q}) begin
                step    <= new_peak_step;
                state_q <= StDone;
              end else begin
                step    <= fine_nxt[STEP_W-1:0];
                cnt_q   <= SettleLoad;
                state_q <= StFSettle;
              end
            end
          end
          StDone: begin
            af_done <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_af_sweep_ctrl.sv
// Self-checking bench for af_sweep_ctrl: a frame/focus-value source driven by a
// sharpness landscape, checked against a list-based model of the sweep.
module tb_af_sweep_ctrl;

  localparam int unsigned STEP_W = 11;
  localparam int unsigned FV_W   = 24;

  logic              clk;
  logic              reset;
  logic              start;
  logic              abort;
  logic              frame_end;
  logic [FV_W-1:0]   fv;
  logic              fv_valid;
  logic [STEP_W-1:0] step;
  logic              busy;
  logic              af_done;
  logic [STEP_W-1:0] peak_step;
  logic [FV_W-1:0]   peak_fv;
  logic              af_err;

  af_sweep_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .frame_end (frame_end),
    .fv        (fv),
    .fv_valid  (fv_valid),
    .step      (step),
    .busy      (busy),
    .af_done   (af_done),
    .peak_step (peak_step),
    .peak_fv   (peak_fv),
    .af_err    (af_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Landscape: 0 = triangle peak at target, 1 = constant, 2 = hashed noise.
  int unsigned mode   = 0;
  int unsigned target = 330;
  int unsigned base   = 1000;
  int unsigned seed   = 0;
  bit          hold192 = 1'b0;
  bit          exp_err = 1'b0;

  int unsigned trace[$];
  int unsigned exp_trace[$];
  int unsigned exp_step;
  int unsigned exp_fv;
  bit          trace_on = 1'b0;
  int          last_step = -1;
  int          done_cnt = 0;

  function automatic int unsigned fv_of(input int unsigned s);
    int unsigned d;
    case (mode)
      0: begin
        d = (s > target) ? s - target : target - s;
        return (d > base) ? 0 : base - d;
      end
      1: return base;
      default: return ((s * 32'd2654435761 + seed) >> 13) & 32'h3FF;
    endcase
  endfunction

  // Frame source: frame_end every 8 cycles, focus value 3 cycles later.
  initial begin
    int ph;
    ph = 0;
    frame_end = 1'b0;
    fv_valid  = 1'b0;
    fv        = '0;
    forever begin
      @(posedge clk);
      #1;
      frame_end = (ph == 0);
      if (ph == 3 && !(hold192 && step == STEP_W'(192))) begin
        fv_valid = 1'b1;
        fv       = FV_W'(fv_of(int'(step)));
      end else begin
        fv_valid = 1'b0;
      end
      ph = (ph + 1) % 8;
    end
  end

  // Record every distinct lens position and every done pulse.
  always @(negedge clk) begin
    if (trace_on && int'(step) != last_step) begin
      trace.push_back(int'(step));
      last_step = int'(step);
    end
    if (af_done === 1'b1) done_cnt = done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic void push_pos(input int unsigned v);
    if (exp_trace.size() == 0 || exp_trace[exp_trace.size()-1] != v) exp_trace.push_back(v);
  endfunction

  // Model: list the positions a sweep visits and pick the earliest strict maximum.
  task automatic build_model();
    int unsigned cpk_s, cpk_f, pk_s, pk_f, lo, hi, f;
    exp_trace.delete();
    cpk_s = 0;
    cpk_f = 0;
    for (int unsigned s = 0; s <= 32'h3F0; s += 64) begin
      push_pos(s);
      if (!(hold192 && s == 192)) begin
        f = fv_of(s);
        if (f > cpk_f) begin
          cpk_f = f;
          cpk_s = s;
        end
      end
    end
    lo = (cpk_s < 16) ? 0 : cpk_s - 16;
    hi = (cpk_s + 16 > 2047) ? 2047 : cpk_s + 16;
    pk_s = cpk_s;
    pk_f = 0;
    for (int unsigned s = lo; s <= hi; s++) begin
      push_pos(s);
      if (!(hold192 && s == 192)) begin
        f = fv_of(s);
        if (f > pk_f) begin
          pk_f = f;
          pk_s = s;
        end
      end
    end
    push_pos(pk_s);
    exp_step = pk_s;
    exp_fv   = pk_f;
  endtask

  task automatic run_af(input string name, input bit inject, input bit with_abort);
    int  d0, first_dec, cmax;
    bit  seen, same;
    build_model();
    d0 = done_cnt;
    start = 1'b1;
    abort = with_abort;
    tick();
    start = 1'b0;
    abort = 1'b0;
    trace.delete();
    last_step = -1;
    trace_on = 1'b1;
    if (with_abort) begin
      total++;
      if (busy !== 1'b1) begin
        bad++;
        $display("FAIL %s start_over_abort: busy=%b want 1", name, busy);
      end
    end
    seen = 1'b0;
    for (int cyc = 0; cyc < 6000 && !seen; cyc++) begin
      if (inject && (cyc % 150) == 75) start = 1'b1;
      tick();
      start = 1'b0;
      if (af_done === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s done_timeout: af_done not seen within 6000 cycles", name);
    end
    repeat (20) tick();
    trace_on = 1'b0;

    total++;
    if (done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt - d0);
    end
    total++;
    if (step !== STEP_W'(exp_step)) begin
      bad++;
      $display("FAIL %s step: got %0d want %0d", name, step, exp_step);
    end
    total++;
    if (peak_step !== STEP_W'(exp_step)) begin
      bad++;
      $display("FAIL %s peak_step: got %0d want %0d", name, peak_step, exp_step);
    end
    total++;
    if (peak_fv !== FV_W'(exp_fv)) begin
      bad++;
      $display("FAIL %s peak_fv: got %0d want %0d", name, peak_fv, exp_fv);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s busy_after: got %b want 0", name, busy);
    end
    total++;
    if (af_err !== exp_err) begin
      bad++;
      $display("FAIL %s af_err: got %b want %b", name, af_err, exp_err);
    end

    same = (trace.size() == exp_trace.size());
    for (int i = 0; same && i < trace.size(); i++) if (trace[i] != exp_trace[i]) same = 1'b0;
    total++;
    if (!same) begin
      bad++;
      $display("FAIL %s trace: got %0d positions want %0d (first got %0d want %0d)", name,
               trace.size(), exp_trace.size(), (trace.size() > 0) ? trace[0] : 0,
               exp_trace[0]);
    end

    // Coarse phase ends at the first backward move into the fine window.
    first_dec = trace.size();
    cmax = 0;
    for (int i = 1; i < trace.size(); i++) begin
      if (trace[i] < trace[i-1]) begin
        first_dec = i;
        break;
      end
    end
    for (int i = 0; i < first_dec; i++) if (int'(trace[i]) > cmax) cmax = trace[i];
    total++;
    if (first_dec != 16 || cmax > 1008) begin
      bad++;
      $display("FAIL %s coarse_positions: got count %0d max %0d want 16 max<=1008", name,
               first_dec, cmax);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) tick();
    total++;
    if ({step, busy, af_done, peak_step, peak_fv, af_err} !== '0) begin
      bad++;
      $display("FAIL reset_values: step=%0d busy=%b done=%b pk=%0d pkfv=%0d err=%b want 0",
               step, busy, af_done, peak_step, peak_fv, af_err);
    end
    reset = 1'b0;
    repeat (30) tick();
    total++;
    if (busy !== 1'b0 || step !== '0) begin
      bad++;
      $display("FAIL idle_hold: busy=%b step=%0d want 0 0", busy, step);
    end
  endtask

  task automatic test_spec_curves();
    mode = 0; target = 330; base = 1000;
    run_af("peak330", 1'b0, 1'b0);
    mode = 0; target = 0; base = 1000;
    run_af("peak0", 1'b0, 1'b0);
    mode = 1; base = 500;
    run_af("const500", 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    bit hit;
    int d0;
    mode = 0; target = 330; base = 1000;
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    hit = 1'b0;
    for (int cyc = 0; cyc < 2000 && !hit; cyc++) begin
      if (step == STEP_W'(128)) hit = 1'b1;
      else tick();
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL abort_reach128: step stuck at %0d want 128", step);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || step !== STEP_W'(128)) begin
      bad++;
      $display("FAIL abort_next: busy=%b step=%0d want 0 128", busy, step);
    end
    repeat (100) tick();
    total++;
    if (done_cnt != d0 || step !== STEP_W'(128) || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_hold: done=%0d step=%0d busy=%b want 0 128 0", done_cnt - d0,
               step, busy);
    end
    run_af("after_abort", 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    int  phase, fes;
    bit  ok;
    mode = 0; target = 330; base = 1000;
    start = 1'b1;
    tick();
    start = 1'b0;
    // phase 0: wait for 960, 1: wait for the move into the fine window, 2: count frames
    phase = 0;
    fes = 0;
    ok = 1'b0;
    for (int cyc = 0; cyc < 4000 && !ok; cyc++) begin
      tick();
      if (phase == 0 && step == STEP_W'(960)) phase = 1;
      else if (phase == 1 && step != STEP_W'(960)) phase = 2;
      else if (phase == 2 && frame_end) begin
        fes++;
        if (fes == 2) ok = 1'b1;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL reset_mid_reach: fine measurement not reached, step=%0d", step);
    end
    tick();
    reset = 1'b1;
    tick();
    total++;
    if ({step, busy, af_done, peak_step, peak_fv, af_err} !== '0) begin
      bad++;
      $display("FAIL reset_mid_values: step=%0d busy=%b done=%b pk=%0d pkfv=%0d err=%b want 0",
               step, busy, af_done, peak_step, peak_fv, af_err);
    end
    reset = 1'b0;
    repeat (40) tick();
    total++;
    if (busy !== 1'b0 || step !== '0) begin
      bad++;
      $display("FAIL reset_mid_idle: busy=%b step=%0d want 0 0", busy, step);
    end
  endtask

  task automatic test_back_to_back();
    mode = 0; target = 700; base = 3000;
    run_af("start_while_busy", 1'b1, 1'b0);
    mode = 2; seed = 32'h1234;
    run_af("start_with_abort", 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      mode = (k % 2 == 0) ? 0 : 2;
      target = $urandom_range(0, 2047);
      base = 3000;
      seed = $urandom;
      run_af($sformatf("rand%0d", k), 1'b0, 1'b0);
    end
  endtask

`ifdef AF_TIMEOUT_EN
  task automatic test_timeout();
    mode = 0; target = 330; base = 1000;
    hold192 = 1'b1;
    exp_err = 1'b1;
    run_af("timeout192", 1'b0, 1'b0);
    hold192 = 1'b0;
    exp_err = 1'b0;
    run_af("timeout_clear", 1'b0, 1'b0);
  endtask
`endif

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    test_reset();
    test_spec_curves();
    test_abort();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
`ifdef AF_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
